// File: rtl/buf_bn_loader_pkg.sv
// Shared definitions for the BN parameter buffer loader.
//  - Default buffer and stream widths.
//  - Loader FSM state type.
//  - Lane-count helpers used to split one stream beat into BN entries.
package buf_bn_loader_pkg;

    localparam int BN_IN_DATA_WIDTH       = 64;
    localparam int BN_BUF_UPDT_ADDR_WIDTH = 11;
    localparam int BN_BUF_UPDT_DATA_WIDTH = 16;
    localparam int BN_LEN_WIDTH           = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a lane index; at least one bit even when a beat holds one entry.
    function automatic int lane_width(input int ratio);
        if (ratio > 1) begin
            return $clog2(ratio);
        end else begin
            return 1;
        end
    endfunction

    localparam int BN_RATIO      = BN_IN_DATA_WIDTH / BN_BUF_UPDT_DATA_WIDTH;
    localparam int BN_LANE_WIDTH = lane_width(BN_RATIO);

endpackage

// File: rtl/buf_bn_loader_if.sv
// Bus bundle between the loader and its neighbours.
//  - cmd_*       : load command (base address, entry count) with valid/ready.
//  - s_*         : wide DMA stream beats with valid/ready; lane 0 in the LSBs.
//  - buf_updt_*  : BN buffer write port (one entry per strobe).
//  - busy, done  : load status.
// Modports: slave = the loader itself, master = the environment driving it.
interface buf_bn_loader_if
    import buf_bn_loader_pkg::*;
#(
    parameter int IN_DATA_WIDTH       = BN_IN_DATA_WIDTH,
    parameter int BUF_UPDT_ADDR_WIDTH = BN_BUF_UPDT_ADDR_WIDTH,
    parameter int BUF_UPDT_DATA_WIDTH = BN_BUF_UPDT_DATA_WIDTH,
    parameter int LEN_WIDTH           = BN_LEN_WIDTH
);

    logic                           cmd_valid;
    logic                           cmd_ready;
    logic [BUF_UPDT_ADDR_WIDTH-1:0] cmd_base;
    logic [LEN_WIDTH-1:0]           cmd_len;
    logic                           s_valid;
    logic                           s_ready;
    logic [IN_DATA_WIDTH-1:0]       s_data;
    logic                           buf_updt_wr_en;
    logic [BUF_UPDT_ADDR_WIDTH-1:0] buf_updt_addr;
    logic [BUF_UPDT_DATA_WIDTH-1:0] buf_updt_data;
    logic                           busy;
    logic                           done;

    modport slave (
        input  cmd_valid, cmd_base, cmd_len, s_valid, s_data,
        output cmd_ready, s_ready, buf_updt_wr_en, buf_updt_addr, buf_updt_data, busy, done
    );

    modport master (
        output cmd_valid, cmd_base, cmd_len, s_valid, s_data,
        input  cmd_ready, s_ready, buf_updt_wr_en, buf_updt_addr, buf_updt_data, busy, done
    );

endinterface

// File: rtl/buf_bn_loader.sv
// Update-side writer for the BN parameter buffer.
// Accepts one load command (base, len), pulls ceil(len/RATIO) wide beats from
// the DMA stream, and writes one BN entry per cycle to consecutive buffer
// addresses (wrapping at the top of the address space), then pulses done.
// Ports:
//  clk  : clock
//  rst  : asynchronous active-high reset
//  bus  : buf_bn_loader_if.slave (command, stream, buffer write port, status)
module buf_bn_loader
    import buf_bn_loader_pkg::*;
#(
    parameter int IN_DATA_WIDTH       = BN_IN_DATA_WIDTH,
    parameter int BUF_UPDT_ADDR_WIDTH = BN_BUF_UPDT_ADDR_WIDTH,
    parameter int BUF_UPDT_DATA_WIDTH = BN_BUF_UPDT_DATA_WIDTH,
    parameter int LEN_WIDTH           = BN_LEN_WIDTH
)(
    input  logic            clk,
    input  logic            rst,
    buf_bn_loader_if.slave  bus
);

    localparam int RATIO  = IN_DATA_WIDTH / BUF_UPDT_DATA_WIDTH;
    localparam int LANE_W = lane_width(RATIO);

    localparam logic [LANE_W-1:0]    LANE_LAST = LANE_W'(RATIO - 1);
    localparam logic [LANE_W-1:0]    LANE_ONE  = LANE_W'(1'b1);
    localparam logic [LANE_W-1:0]    LANE_ZERO = {LANE_W{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1'b1);
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [BUF_UPDT_ADDR_WIDTH-1:0] ADDR_ONE  = BUF_UPDT_ADDR_WIDTH'(1'b1);
    localparam logic [BUF_UPDT_ADDR_WIDTH-1:0] ADDR_ZERO = {BUF_UPDT_ADDR_WIDTH{1'b0}};
    localparam logic [BUF_UPDT_DATA_WIDTH-1:0] DATA_ZERO = {BUF_UPDT_DATA_WIDTH{1'b0}};
    localparam logic [IN_DATA_WIDTH-1:0]       BEAT_ZERO = {IN_DATA_WIDTH{1'b0}};

    state_e                         state_r;
    logic [BUF_UPDT_ADDR_WIDTH-1:0] addr_r;       // next address to write
    logic [LEN_WIDTH-1:0]           left_r;       // entries still to write
    logic [LANE_W-1:0]              lane_r;       // lane currently at the bottom of beat_data_r
    logic                           beat_vld_r;
    logic [IN_DATA_WIDTH-1:0]       beat_data_r;  // shifted down one lane per write
    logic                           wr_en_r;
    logic [BUF_UPDT_ADDR_WIDTH-1:0] wr_addr_r;
    logic [BUF_UPDT_DATA_WIDTH-1:0] wr_data_r;
    logic                           busy_r;
    logic                           done_r;

    logic lane_last_s;
    logic left_last_s;
    logic left_more_s;
    logic cmd_ready_s;
    logic s_ready_s;
    logic cmd_fire_s;
    logic s_fire_s;

    assign lane_last_s = (lane_r == LANE_LAST);
    assign left_last_s = (left_r == LEN_ONE);
    assign left_more_s = (left_r > LEN_ONE);
    assign cmd_ready_s = (state_r == IDLE);
    // A new beat may land in the same cycle the last lane of the current one
    // is written, but only if the load still needs more entries after it.
    assign s_ready_s   = (state_r == LOAD) && (!beat_vld_r || (lane_last_s && left_more_s));
    assign cmd_fire_s  = bus.cmd_valid && cmd_ready_s;
    assign s_fire_s    = bus.s_valid && s_ready_s;

    assign bus.cmd_ready      = cmd_ready_s;
    assign bus.s_ready        = s_ready_s;
    assign bus.buf_updt_wr_en = wr_en_r;
    assign bus.buf_updt_addr  = wr_addr_r;
    assign bus.buf_updt_data  = wr_data_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;

    // Load FSM, beat register with lane tracking, and registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            addr_r      <= ADDR_ZERO;
            left_r      <= LEN_ZERO;
            lane_r      <= LANE_ZERO;
            beat_vld_r  <= 1'b0;
            beat_data_r <= BEAT_ZERO;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= ADDR_ZERO;
            wr_data_r   <= DATA_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            wr_en_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_fire_s) begin
                        addr_r     <= bus.cmd_base;
                        left_r     <= bus.cmd_len;
                        lane_r     <= LANE_ZERO;
                        beat_vld_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (bus.cmd_len == LEN_ZERO) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (beat_vld_r) begin
                        wr_en_r     <= 1'b1;
                        wr_addr_r   <= addr_r;
                        wr_data_r   <= beat_data_r[BUF_UPDT_DATA_WIDTH-1:0];
                        beat_data_r <= beat_data_r >> BUF_UPDT_DATA_WIDTH;
                        addr_r      <= addr_r + ADDR_ONE;
                        left_r      <= left_r - LEN_ONE;
                        lane_r      <= lane_r + LANE_ONE;
                        // Beat exhausted, or remaining lanes lie past len and are dropped.
                        if (lane_last_s || left_last_s) begin
                            beat_vld_r <= 1'b0;
                            lane_r     <= LANE_ZERO;
                        end
                        if (left_last_s) begin
                            state_r <= DONE;
                        end
                    end
                    // A fresh beat overrides the emptying above.
                    if (s_fire_s) begin
                        beat_data_r <= bus.s_data;
                        beat_vld_r  <= 1'b1;
                        lane_r      <= LANE_ZERO;
                    end
                end
                DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    beat_vld_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buf_bn_loader.sv
// Self-checking bench for buf_bn_loader: directed loads with random beat data
// and random stream gaps, checked against a plain arithmetic reference model
// (entry i of a load goes to (base+i) mod 2^ADDR_W and carries lane i%RATIO
// of beat i/RATIO).
module tb_buf_bn_loader;
    import buf_bn_loader_pkg::*;

    localparam int W  = BN_BUF_UPDT_DATA_WIDTH;
    localparam int AW = BN_BUF_UPDT_ADDR_WIDTH;
    localparam int R  = BN_IN_DATA_WIDTH / BN_BUF_UPDT_DATA_WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    buf_bn_loader_if bus ();

    buf_bn_loader #(
        .IN_DATA_WIDTH       (BN_IN_DATA_WIDTH),
        .BUF_UPDT_ADDR_WIDTH (BN_BUF_UPDT_ADDR_WIDTH),
        .BUF_UPDT_DATA_WIDTH (BN_BUF_UPDT_DATA_WIDTH),
        .LEN_WIDTH           (BN_LEN_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port and done monitor, sampled mid-cycle.
    int          wr_cyc_q[$];
    logic [10:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          done_cyc_q[$];
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.buf_updt_wr_en === 1'b1) begin
                wr_cyc_q.push_back(cyc);
                wr_addr_q.push_back(bus.buf_updt_addr);
                wr_data_q.push_back(bus.buf_updt_data);
            end
            if (bus.done === 1'b1) done_cyc_q.push_back(cyc);
        end
    end

    logic [63:0] beats_q[$];
    int accepted, extra_cmd, sready_seen, first_acc_cyc, cmd_cyc;
    bit aborted;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input int base, input int i);
        return AW'((base + i) % (1 << AW));
    endfunction

    function automatic logic [W-1:0] exp_data(input int i);
        logic [63:0] b;
        b = beats_q[i / R];
        return W'(b >> (W * (i % R)));
    endfunction

    task automatic run_load(input int base, input int len, input int valid_pct,
                            input bit spam_cmd, input int abort_after);
        int idx;
        int nwr;
        int guard;
        bit got_done;
        wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); done_cyc_q.delete();
        accepted = 0; extra_cmd = 0; sready_seen = 0; first_acc_cyc = -1; aborted = 0;
        idx = 0; nwr = 0; got_done = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = AW'(base);
        bus.cmd_len   = 12'(len);
        cmd_cyc       = cyc;
        check("cmd_ready_idle", {63'd0, bus.cmd_ready}, 64'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (guard = 0; guard < 2000; guard++) begin
            if (bus.buf_updt_wr_en === 1'b1) nwr++;
            if (bus.done === 1'b1) begin
                got_done = 1;
                break;
            end
            if (abort_after > 0 && nwr >= abort_after) begin
                aborted = 1;
                break;
            end
            if (bus.s_ready === 1'b1) sready_seen++;
            if (idx < beats_q.size() && $urandom_range(99) < valid_pct) begin
                bus.s_valid = 1'b1;
                bus.s_data  = beats_q[idx];
            end else begin
                bus.s_valid = 1'b0;
                bus.s_data  = {$urandom(), $urandom()};
            end
            if (spam_cmd) begin
                bus.cmd_valid = 1'($urandom_range(1));
                bus.cmd_base  = AW'($urandom());
                bus.cmd_len   = 12'($urandom());
            end
            if (bus.s_valid && bus.s_ready) begin
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                accepted++;
                idx++;
            end
            if (bus.cmd_valid && bus.cmd_ready) extra_cmd++;
            @(negedge clk);
        end
        bus.s_valid   = 1'b0;
        bus.cmd_valid = 1'b0;
        if (!aborted) begin
            check("done_seen", {63'd0, got_done}, 64'd1);
            @(negedge clk);
            check("done_one_cycle", {63'd0, bus.done}, 64'd0);
            check("busy_after", {63'd0, bus.busy}, 64'd0);
            check("n_writes", 64'(wr_cyc_q.size()), 64'(len));
            for (int i = 0; i < wr_cyc_q.size() && i < len; i++) begin
                check($sformatf("addr[%0d]", i), 64'(wr_addr_q[i]), 64'(exp_addr(base, i)));
                check($sformatf("data[%0d]", i), 64'(wr_data_q[i]), 64'(exp_data(i)));
            end
            check("beats_accepted", 64'(accepted), 64'((len + R - 1) / R));
            check("extra_cmd", 64'(extra_cmd), 64'd0);
            check("n_done", 64'(done_cyc_q.size()), 64'd1);
            if (done_cyc_q.size() > 0) begin
                if (len != 0 && wr_cyc_q.size() > 0)
                    check("done_after_last_wr", 64'(done_cyc_q[0]), 64'(wr_cyc_q[wr_cyc_q.size()-1] + 1));
                else
                    check("done_len0_latency", 64'(done_cyc_q[0] - cmd_cyc), 64'd2);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},     {63'd0, bus.buf_updt_wr_en}, 64'd0);
        check({tag, "_addr"},      64'(bus.buf_updt_addr), 64'd0);
        check({tag, "_data"},      64'(bus.buf_updt_data), 64'd0);
        check({tag, "_busy"},      {63'd0, bus.busy}, 64'd0);
        check({tag, "_done"},      {63'd0, bus.done}, 64'd0);
        check({tag, "_s_ready"},   {63'd0, bus.s_ready}, 64'd0);
        check({tag, "_cmd_ready"}, {63'd0, bus.cmd_ready}, 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: len=8, two back-to-back beats, fixed data.
        beats_q = {64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005};
        run_load(32'h010, 8, 100, 0, 0);
        check("t1_first_wr_latency", 64'(wr_cyc_q.size() > 0 ? wr_cyc_q[0] - first_acc_cyc : -1), 64'd2);
        for (int i = 1; i < wr_cyc_q.size(); i++)
            check($sformatf("t1_wr_consecutive[%0d]", i), 64'(wr_cyc_q[i] - wr_cyc_q[0]), 64'(i));

        // 2: len=5, three beats offered; only two may be taken.
        beats_q = {};
        for (int i = 0; i < 3; i++) beats_q.push_back({$urandom(), $urandom()});
        run_load(32'h123, 5, 100, 0, 0);

        // 3: address wrap at the top of the buffer.
        beats_q = {{$urandom(), $urandom()}};
        run_load(32'h7FE, 4, 100, 0, 0);

        // 4: len=0 -> done only, no beats, no writes.
        beats_q = {{$urandom(), $urandom()}};
        run_load(32'h055, 0, 100, 0, 0);
        check("t4_s_ready_never", 64'(sready_seen), 64'd0);

        // 5: len=64 with random stream gaps and stray commands.
        beats_q = {};
        for (int i = 0; i < 16; i++) beats_q.push_back({$urandom(), $urandom()});
        run_load($urandom_range(2047), 64, 50, 1, 0);

        // 6: reset mid-load after 3 writes, then a clean load.
        beats_q = {};
        for (int i = 0; i < 2; i++) beats_q.push_back({$urandom(), $urandom()});
        run_load(32'h200, 8, 100, 0, 3);
        check("t6_aborted", {63'd0, aborted}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_async_reset");
        done_cyc_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_no_done_after_abort", 64'(done_cyc_q.size()), 64'd0);
        beats_q = {};
        for (int i = 0; i < 3; i++) beats_q.push_back({$urandom(), $urandom()});
        run_load(32'h3F0, 10, 70, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
